gestor_tramas: RTL and testbench

Frame scheduler for the UART receive byte stream. It sits between the byte receiver and the parameter consumers (time, alarm, brightness). It recognises header-delimited ASCII frames and assembles the payload. It then routes each frame to exactly one consumer through a valid/ack handshake, with inter-byte timeout and error/overrun reporting.

---
 rtl/gestor_tramas.sv | 174 +++++++++++++++++
 tb/tb_gestor_tramas.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gestor_tramas.sv
// Frame scheduler for the UART receive stream: recognises header-delimited
// ASCII digit frames and hands each one to a single consumer via valid/ack.
module gestor_tramas #(
   parameter int         N_BYTES     = 6,
   parameter logic [7:0] HDR_HORA    = 8'd90,
   parameter logic [7:0] HDR_ALARMA  = 8'd65,
   parameter logic [7:0] HDR_BRILLO  = 8'd66,
   parameter int         TIMEOUT_CYC = 50_000_000
) (
   input  logic                   clk,
   input  logic                   init,
   input  logic [7:0]             rx_dato,
   input  logic                   rx_valid,
   input  logic                   out_ack,
   output logic [8*N_BYTES-1:0]   out_payload,
   output logic [1:0]             out_dest,
   output logic                   out_valid,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   busy,
   output logic [7:0]             err_cnt
);

   localparam int PW = 8 * N_BYTES;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int CW = $clog2(N_BYTES + 1);
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CLAST = CW'(N_BYTES - 1);
   localparam logic [PW-1:0] PAY_RST = {N_BYTES{8'h30}};

   typedef enum logic [1:0] {IDLE, PAYLOAD, TRAIL, HOLD} state_t;

   state_t          state_q, state_d;
   logic [7:0]      hdr_q, hdr_d;
   logic [1:0]      dest_q, dest_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [PW-1:0]   shift_q, shift_d;
   logic [PW-1:0]   pay_q, pay_d;
   logic [1:0]      odest_q, odest_d;
   logic            ovalid_q, ovalid_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic [7:0]      errc_q, errc_d;

   function automatic logic is_hdr(input logic [7:0] b);
      return (b == HDR_HORA) || (b == HDR_ALARMA) || (b == HDR_BRILLO);
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= 8'd48) && (b <= 8'd57);
   endfunction

   function automatic logic [1:0] dest_of(input logic [7:0] b);
      if (b == HDR_HORA)        return 2'd0;
      else if (b == HDR_ALARMA) return 2'd1;
      else                      return 2'd2;
   endfunction

   always_comb begin
      state_d  = state_q;
      hdr_d    = hdr_q;
      dest_d   = dest_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      shift_d  = shift_q;
      pay_d    = pay_q;
      odest_d  = odest_q;
      ovalid_d = ovalid_q;
      ferr_d   = 1'b0;
      ovr_d    = 1'b0;
      errc_d   = errc_q;

      case (state_q)
         IDLE: begin
            if (rx_valid && is_hdr(rx_dato)) begin
               hdr_d   = rx_dato;
               dest_d  = dest_of(rx_dato);
               cnt_d   = '0;
               timer_d = '0;
               state_d = PAYLOAD;
            end
         end
         PAYLOAD, TRAIL: begin
            if (!rx_valid) begin
               if (timer_q == TMAX) begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end else begin
               timer_d = '0;
               if (rx_dato != 8'd0) begin
                  if (state_q == PAYLOAD) begin
                     if (is_digit(rx_dato)) begin
                        shift_d = {rx_dato, shift_q[PW-1:8]};
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CLAST) state_d = TRAIL;
                     end else if (is_hdr(rx_dato)) begin
                        // A fresh header mid-payload restarts the frame from it.
                        ferr_d  = 1'b1;
                        hdr_d   = rx_dato;
                        dest_d  = dest_of(rx_dato);
                        cnt_d   = '0;
                        shift_d = '0;
                     end else begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                     end
                  end else if (rx_dato == hdr_q) begin
                     pay_d    = shift_q;
                     odest_d  = dest_q;
                     ovalid_d = 1'b1;
                     state_d  = HOLD;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         HOLD: begin
            if (rx_valid && (rx_dato != 8'd0)) ovr_d = 1'b1;
            if (out_ack) begin
               ovalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ferr_d && (errc_q != 8'hFF)) errc_d = errc_q + 8'd1;
   end

   always_ff @(posedge clk or negedge init) begin
      if (!init) begin
         state_q  <= IDLE;
         hdr_q    <= '0;
         dest_q   <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
         shift_q  <= '0;
         pay_q    <= PAY_RST;
         odest_q  <= '0;
         ovalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         errc_q   <= '0;
      end else begin
         state_q  <= state_d;
         hdr_q    <= hdr_d;
         dest_q   <= dest_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         shift_q  <= shift_d;
         pay_q    <= pay_d;
         odest_q  <= odest_d;
         ovalid_q <= ovalid_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
         errc_q   <= errc_d;
      end
   end

   assign out_payload = pay_q;
   assign out_dest    = odest_q;
   assign out_valid   = ovalid_q;
   assign frame_err   = ferr_q;
   assign overrun     = ovr_q;
   assign err_cnt     = errc_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gestor_tramas.sv
// Directed and random bench for gestor_tramas against a byte-queue frame model.
module tb_gestor_tramas;

   localparam int N  = 6;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          init;
   logic [7:0]    rx_dato;
   logic          rx_valid;
   logic          out_ack;
   logic [8*N-1:0] out_payload;
   logic [1:0]    out_dest;
   logic          out_valid;
   logic          frame_err;
   logic          overrun;
   logic          busy;
   logic [7:0]    err_cnt;

   gestor_tramas #(.N_BYTES(N), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .init(init), .rx_dato(rx_dato), .rx_valid(rx_valid),
      .out_ack(out_ack), .out_payload(out_payload), .out_dest(out_dest),
      .out_valid(out_valid), .frame_err(frame_err), .overrun(overrun),
      .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: bytes of the frame under construction (header first),
   // plus the frame currently offered to the consumer.
   logic [7:0]     frame[$];
   bit             pend;
   logic [8*N-1:0] m_pay;
   logic [1:0]     m_dest;
   int             idle;
   int             m_err;
   bit             m_fe, m_ov;

   function automatic bit m_is_hdr(input logic [7:0] b);
      return b == "Z" || b == "A" || b == "B";
   endfunction

   function automatic logic [1:0] m_dest_of(input logic [7:0] b);
      case (b)
         "Z":     return 2'd0;
         "A":     return 2'd1;
         default: return 2'd2;
      endcase
   endfunction

   task automatic model_reset();
      frame.delete();
      pend   = 0;
      m_pay  = {N{8'h30}};
      m_dest = 0;
      idle   = 0;
      m_err  = 0;
      m_fe   = 0;
      m_ov   = 0;
   endtask

   task automatic model_edge(input bit v, input logic [7:0] d, input bit ack);
      m_fe = 0;
      m_ov = 0;
      if (pend) begin
         if (v && d != 0) m_ov = 1;
         if (ack) pend = 0;
      end else if (frame.size() == 0) begin
         if (v && m_is_hdr(d)) begin
            frame.push_back(d);
            idle = 0;
         end
      end else if (!v) begin
         idle++;
         if (idle == TO) begin
            m_fe = 1;
            frame.delete();
         end
      end else begin
         idle = 0;
         if (d != 0) begin
            if (frame.size() <= N) begin
               if (d >= "0" && d <= "9") frame.push_back(d);
               else if (m_is_hdr(d)) begin
                  m_fe = 1;
                  frame.delete();
                  frame.push_back(d);
               end else begin
                  m_fe = 1;
                  frame.delete();
               end
            end else if (d == frame[0]) begin
               for (int i = 0; i < N; i++) m_pay[8*i +: 8] = frame[i+1];
               m_dest = m_dest_of(frame[0]);
               pend   = 1;
               frame.delete();
            end else begin
               m_fe = 1;
               frame.delete();
            end
         end
      end
      if (m_fe && m_err < 255) m_err++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 64'(out_valid), 64'(pend));
      chk("out_payload", 64'(out_payload), 64'(m_pay));
      chk("out_dest", 64'(out_dest), 64'(m_dest));
      chk("frame_err", 64'(frame_err), 64'(m_fe));
      chk("overrun", 64'(overrun), 64'(m_ov));
      chk("busy", 64'(busy), 64'((frame.size() != 0) || pend));
      chk("err_cnt", 64'(err_cnt), 64'(m_err));
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit ack);
      rx_valid = v;
      rx_dato  = d;
      out_ack  = ack;
      @(posedge clk);
      #1;
      model_edge(v, d, ack);
      check_all();
      rx_valid = 1'b0;
      rx_dato  = 8'd0;
      out_ack  = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
   endtask

   initial begin
      logic [7:0] junk[3];
      logic [7:0] hdrs[3];
      logic [7:0] b;
      int r;
      junk = '{8'h78, 8'h0D, 8'hFF};
      hdrs = '{"Z", "A", "B"};

      init = 1'b0; rx_valid = 1'b0; rx_dato = 8'd0; out_ack = 1'b0;
      #12;
      model_reset();
      check_all();
      chk("rst_payload", 64'(out_payload), 64'h303030303030);
      @(negedge clk);
      init = 1'b1;

      send_str("Z123456Z");
      chk("time_payload", 64'(out_payload), 64'h363534333231);
      chk("time_valid", 64'(out_valid), 64'd1);
      step(1'b0, 8'd0, 1'b0);
      step(1'b0, 8'd0, 1'b0);
      step(1'b0, 8'd0, 1'b1);
      chk("time_ack_valid", 64'(out_valid), 64'd0);

      send_str("A1x");
      chk("err_cnt_1", 64'(err_cnt), 64'd1);
      send_str("A1Z");
      chk("resync_err", 64'(frame_err), 64'd1);
      send_str("093000Z");
      chk("resync_payload", 64'(out_payload), 64'h303030333930);
      chk("resync_dest", 64'(out_dest), 64'd0);
      chk("err_cnt_2", 64'(err_cnt), 64'd2);
      step(1'b0, 8'd0, 1'b1);

      send_str("B1");
      repeat (14) step(1'b0, 8'd0, 1'b0);
      step(1'b1, "2", 1'b0);
      repeat (15) step(1'b0, 8'd0, 1'b0);
      chk("to_restart_busy", 64'(busy), 64'd1);
      step(1'b0, 8'd0, 1'b0);
      chk("to_restart_err", 64'(frame_err), 64'd1);
      send_str("B1");
      repeat (15) step(1'b0, 8'd0, 1'b0);
      chk("to_early", 64'(frame_err), 64'd0);
      step(1'b0, 8'd0, 1'b0);
      chk("to_err", 64'(frame_err), 64'd1);
      chk("to_busy", 64'(busy), 64'd0);

      send_str("B123456B");
      step(1'b1, "Z", 1'b0);
      chk("ovr_pulse", 64'(overrun), 64'd1);
      chk("ovr_payload", 64'(out_payload), 64'h363534333231);
      chk("ovr_dest", 64'(out_dest), 64'd2);
      step(1'b1, "Z", 1'b1);
      chk("ovr_ack_pulse", 64'(overrun), 64'd1);
      chk("ovr_ack_valid", 64'(out_valid), 64'd0);
      chk("ovr_ack_busy", 64'(busy), 64'd0);

      send_str("Z123456A");
      chk("term_err", 64'(frame_err), 64'd1);
      chk("term_valid", 64'(out_valid), 64'd0);
      send_str("Z12");
      #2 init = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("arst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      init = 1'b1;
      step(1'b0, 8'd0, 1'b0);

      for (int it = 0; it < 800; it++) begin
         if ($urandom_range(0, 80) == 0) repeat (TO + 1) step(1'b0, 8'd0, 1'b0);
         r = $urandom_range(0, 9);
         if (r < 2)      b = hdrs[$urandom_range(0, 2)];
         else if (r < 9) b = 8'(8'd48 + $urandom_range(0, 9));
         else            b = junk[$urandom_range(0, 2)];
         step($urandom_range(0, 2) != 0, b, $urandom_range(0, 4) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
